// File: rtl/aes_pkg.sv
// Shared GF(2^8) helpers, column type, coefficients and FSM states
// for the iterative MixColumns engine.
package aes_pkg;

  typedef logic [0:3][7:0] col_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Row 0 of each circulant matrix; row r is this rotated right by r.
  localparam col_t FWD_COEF = 32'h02030101;
  localparam col_t INV_COEF = 32'h0e0b0d09;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] m;
    p = '0;
    x = a;
    m = b;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ x;
      x = xtime(x);
      m = m >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/mix_column.sv
// Combinational forward/inverse MixColumns on one 32-bit column.
// Both transforms are built from constant xtime chains and muxed.
module mix_column
  import aes_pkg::*;
(
  input  col_t column,
  input  logic inv,
  output col_t mixed
);

  col_t fwd_col;
  col_t inv_col;

  always_comb begin
    fwd_col = '0;
    inv_col = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        fwd_col[r] = fwd_col[r]
                   ^ gf_mul(column[j], FWD_COEF[2'(j - r)]);
        inv_col[r] = inv_col[r]
                   ^ gf_mul(column[j], INV_COEF[2'(j - r)]);
      end
    end
    mixed = inv ? inv_col : fwd_col;
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative MixColumns engine: transforms COLS_PER_CYCLE columns per
// cycle in place, valid/ready on both sides, one mode bit per block.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int NB             = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [0:32*NB-1] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:32*NB-1] out_data,
  output logic             busy
);

  localparam int NG  = NB / COLS_PER_CYCLE;
  localparam int CW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int CIW = $clog2(NB);
  localparam logic [CW-1:0] LAST = CW'(NG - 1);

  if ((NB < 4) || (NB > 8) ||
      (COLS_PER_CYCLE < 1) ||
      ((NB % COLS_PER_CYCLE) != 0)) begin : g_bad_param
    $error("mix_columns_engine: illegal NB/COLS_PER_CYCLE");
  end

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 mode;
  logic [0:NB-1][31:0]  work;

  logic [CIW-1:0] col_idx [COLS_PER_CYCLE];
  col_t           col_in  [COLS_PER_CYCLE];
  col_t           col_out [COLS_PER_CYCLE];

  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    assign col_idx[i] = CIW'(int'(cnt) * COLS_PER_CYCLE + i);
    assign col_in[i]  = work[col_idx[i]];

    mix_column u_mix (
      .column (col_in[i]),
      .inv    (mode),
      .mixed  (col_out[i])
    );
  end

  // DONE hands ready straight through so a waiting block
  // can be taken on the same edge the result leaves.
  assign in_ready = !reset &&
                    ((state == IDLE) ||
                     ((state == DONE) && out_ready));

  assign out_data = work;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      work      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          if (in_valid && in_ready) begin
            work      <= in_data;
            mode      <= in_inv;
            cnt       <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            work[col_idx[i]] <= col_out[i];
          end
          if (cnt == LAST) begin
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Self-checking bench for mix_columns_engine: directed vectors,
// back-pressure, reset, and a randomized parameter sweep.
module tb_mix_columns_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [0:127] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_data;
  logic         busy;

  mix_columns_engine #(
    .NB             (4),
    .COLS_PER_CYCLE (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  localparam int NSW = 8;
  localparam int SW_NB  [NSW] = '{4, 4, 4, 6, 6, 8, 8, 8};
  localparam int SW_CPC [NSW] = '{1, 2, 4, 1, 2, 1, 2, 4};

  logic         sw_in_valid;
  logic         sw_in_inv;
  logic         sw_out_ready;
  logic [0:255] sw_in_data;
  logic         sw_in_ready  [NSW];
  logic         sw_out_valid [NSW];
  logic         sw_busy      [NSW];
  logic [0:255] sw_out_data  [NSW];

  for (genvar k = 0; k < NSW; k++) begin : g_sw
    localparam int N = SW_NB[k];
    localparam int C = SW_CPC[k];
    logic [0:32*N-1] od;
    logic [0:255]    pad;

    mix_columns_engine #(
      .NB             (N),
      .COLS_PER_CYCLE (C)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (sw_in_valid),
      .in_ready  (sw_in_ready[k]),
      .in_inv    (sw_in_inv),
      .in_data   (sw_in_data[0:32*N-1]),
      .out_valid (sw_out_valid[k]),
      .out_ready (sw_out_ready),
      .out_data  (od),
      .busy      (sw_busy[k])
    );

    always_comb begin
      pad = '0;
      pad[0:32*N-1] = od;
    end
    assign sw_out_data[k] = pad;
  end

  // Reference: textbook matrix product over GF(2^8), poly 0x11B.
  localparam int MX [2][4][4] = '{
    '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}},
    '{'{14, 11, 13, 9}, '{9, 14, 11, 13},
      '{13, 9, 14, 11}, '{11, 13, 9, 14}}
  };

  function automatic int gmul(int a, int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ a;
      a = a << 1;
      if ((a & 'h100) != 0) a = a ^ 'h11b;
    end
    return p;
  endfunction

  function automatic logic [0:255] ref_mix(
    logic [0:255] d, int nb, bit inv
  );
    int b [32];
    int o [32];
    logic [0:255] t;
    logic [0:255] r;
    int acc;
    t = d;
    for (int k = 0; k < 32; k++) begin
      b[k] = int'(t[0:7]);
      o[k] = 0;
      t = t << 8;
    end
    for (int c = 0; c < nb; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(b[4*c+j], MX[int'(inv)][row][j]);
        o[4*c+row] = acc;
      end
    end
    r = '0;
    for (int k = 0; k < 32; k++) r = {r[8:255], 8'(o[k])};
    return r;
  endfunction

  function automatic logic [0:127] ref4(logic [0:127] d, bit inv);
    logic [0:255] t;
    t = ref_mix({d, 128'b0}, 4, inv);
    return t[0:127];
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(
    input  logic [0:127] d,
    input  bit           inv,
    input  bit           release_out,
    output logic [0:127] res,
    output int           lat
  );
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    lat      = 0;
    @(negedge clk);
    in_valid = 1'b0;
    in_inv   = ~inv;
    in_data  = rnd128();
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = out_data;
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%b busy=%b want 0/0",
               out_valid, busy);
    end
    checks++;
    if (out_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", out_data);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_fips();
    logic [0:127] a;
    logic [0:127] fa;
    logic [0:127] res;
    int lat;
    a  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    fa = 128'h046681e5e0cb199a48f8d37a2806264c;
    run_block(a, 1'b0, 1'b1, res, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL fips_latency: got %0d want 5", lat);
    end
    checks++;
    if (res !== fa) begin
      errors++;
      $display("FAIL fips_fwd: got %h want %h", res, fa);
    end
    run_block(fa, 1'b1, 1'b1, res, lat);
    checks++;
    if (res !== a) begin
      errors++;
      $display("FAIL fips_inv: got %h want %h", res, a);
    end
  endtask

  localparam logic [31:0] VIN [6] = '{
    32'hdb135345, 32'hf20a225c, 32'h01010101,
    32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c
  };
  localparam logic [31:0] VOUT [6] = '{
    32'h8e4da1bc, 32'h9fdc589d, 32'h01010101,
    32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8
  };

  task automatic test_columns();
    logic [0:127] blk;
    logic [0:127] res;
    logic [0:127] back;
    logic [0:127] t;
    int idx;
    int lat;
    for (int b = 0; b < 2; b++) begin
      blk = '0;
      for (int c = 0; c < 4; c++)
        blk = {blk[32:127], VIN[(4*b + c) % 6]};
      run_block(blk, 1'b0, 1'b1, res, lat);
      run_block(res, 1'b1, 1'b1, back, lat);
      for (int c = 0; c < 4; c++) begin
        idx = (4*b + c) % 6;
        t = res << (32*c);
        checks++;
        if (t[0:31] !== VOUT[idx]) begin
          errors++;
          $display("FAIL col_fwd[%0d]: got %h want %h",
                   idx, t[0:31], VOUT[idx]);
        end
        t = back << (32*c);
        checks++;
        if (t[0:31] !== VIN[idx]) begin
          errors++;
          $display("FAIL col_inv[%0d]: got %h want %h",
                   idx, t[0:31], VIN[idx]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [0:127] d1;
    logic [0:127] d2;
    logic [0:127] e1;
    logic [0:127] res;
    int lat;
    d1 = rnd128();
    d2 = rnd128();
    e1 = ref4(d1, 1'b0);
    run_block(d1, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== e1) begin
      errors++;
      $display("FAIL bp_first: got %h want %h", res, e1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e1 ||
          in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%b rdy=%b data=%h want 1/0/%h",
                 i, out_valid, in_ready, out_data, e1);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d2;
    in_inv    = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_passthru: in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    lat = 1;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_bubble: busy=%b out_valid=%b want 1/0",
               busy, out_valid);
    end
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 5 || out_data !== ref4(d2, 1'b1)) begin
      errors++;
      $display("FAIL bp_second: lat=%0d data=%h want 5/%h",
               lat, out_data, ref4(d2, 1'b1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [0:127] d;
    logic [0:127] res;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = rnd128();
    in_inv   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: v=%b busy=%b data=%h want 0/0/0",
               out_valid, busy, out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_quiet[%0d]: out_valid=%b want 0",
                 i, out_valid);
      end
    end
    d = rnd128();
    run_block(d, 1'b0, 1'b1, res, lat);
    checks++;
    if (res !== ref4(d, 1'b0) || lat !== 5) begin
      errors++;
      $display("FAIL mid_reset_next: lat=%0d data=%h want 5/%h",
               lat, res, ref4(d, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [0:127] d;
    logic [0:127] res;
    bit inv;
    int lat;
    for (int n = 0; n < 20; n++) begin
      d   = rnd128();
      inv = 1'($urandom_range(0, 1));
      run_block(d, inv, 1'b1, res, lat);
      checks++;
      if (res !== ref4(d, inv) || lat !== 5) begin
        errors++;
        $display("FAIL rand[%0d] inv=%0d: lat=%0d got %h want %h",
                 n, inv, lat, res, ref4(d, inv));
      end
    end
  endtask

  task automatic test_sweep();
    logic [0:255] d;
    logic [0:255] fwd8;
    logic [0:255] all1;
    logic [0:255] mask;
    logic [0:255] exp_d;
    int lat [NSW];
    bit seen [NSW];
    bit all_seen;
    int cyc;
    all1 = '1;
    for (int n = 0; n < 1000; n++) begin
      d = '0;
      for (int w = 0; w < 8; w++) d = {d[32:255], 32'($urandom)};
      fwd8 = ref_mix(d, 8, 1'b0);
      for (int pass = 0; pass < 2; pass++) begin
        @(negedge clk);
        sw_in_valid = 1'b1;
        sw_in_data  = (pass == 0) ? d : fwd8;
        sw_in_inv   = (pass == 1);
        cyc = 0;
        for (int k = 0; k < NSW; k++) begin
          seen[k] = 1'b0;
          lat[k]  = -1;
        end
        @(negedge clk);
        sw_in_valid = 1'b0;
        sw_in_inv   = ~sw_in_inv;
        cyc = 1;
        forever begin
          all_seen = 1'b1;
          for (int k = 0; k < NSW; k++) begin
            if (!seen[k] && sw_out_valid[k]) begin
              seen[k] = 1'b1;
              lat[k]  = cyc;
            end
            if (!seen[k]) all_seen = 1'b0;
          end
          if (all_seen || cyc >= 40) break;
          @(negedge clk);
          cyc++;
        end
        for (int k = 0; k < NSW; k++) begin
          mask = ~(all1 >> (32 * SW_NB[k]));
          if (pass == 0) exp_d = ref_mix(d, SW_NB[k], 1'b0);
          else           exp_d = d & mask;
          checks++;
          if (lat[k] !== SW_NB[k] / SW_CPC[k] + 1) begin
            errors++;
            $display("FAIL sweep_lat nb=%0d cpc=%0d: got %0d want %0d",
                     SW_NB[k], SW_CPC[k], lat[k],
                     SW_NB[k] / SW_CPC[k] + 1);
          end
          checks++;
          if (sw_out_data[k] !== exp_d) begin
            errors++;
            $display("FAIL sweep_data nb=%0d cpc=%0d pass=%0d: got %h want %h",
                     SW_NB[k], SW_CPC[k], pass, sw_out_data[k], exp_d);
          end
        end
        sw_out_ready = 1'b1;
        @(negedge clk);
        sw_out_ready = 1'b0;
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_inv       = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    sw_in_valid  = 1'b0;
    sw_in_inv    = 1'b0;
    sw_in_data   = '0;
    sw_out_ready = 1'b0;
    test_reset();
    test_fips();
    test_columns();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
